// File: rtl/sdram_tester_pkg.sv
// Shared types for the SDRAM tester: FSM state encoding and data pattern modes.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WGAP,
    ST_RREQ,
    ST_RGAP,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    PAT_CONST = 2'd0,
    PAT_ADDR  = 2'd1,
    PAT_INC   = 2'd2,
    PAT_WALK  = 2'd3
  } pat_mode_t;

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational test-pattern generator; one instance feeds both write data and read compare.
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
) (
  input  pat_mode_t          mode,
  input  logic [DATA_W-1:0]  seed,
  input  logic [ADDR_W:0]    index,
  input  logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  data
);

  localparam int ROT_W = $clog2(DATA_W) + 1;

  logic [ROT_W-1:0] rot;

  always_comb begin
    rot  = ROT_W'(index % DATA_W);
    data = '0;
    case (mode)
      PAT_CONST: data = seed;
      PAT_ADDR:  data = DATA_W'(addr);
      PAT_INC:   data = seed + DATA_W'(index);
      // a right shift by the full width yields zero, so rot==0 degenerates to seed
      PAT_WALK:  data = (seed << rot) | (seed >> (DATA_W - rot));
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/sdram_tester.sv
// Memory tester: writes a pattern over a word range, reads it back, counts mismatches,
// and aborts through a per-request watchdog if the controller stops responding.
module sdram_tester
  import sdram_tester_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            state;
  pat_mode_t         mode_r;
  logic [DATA_W-1:0] seed_r;
  logic [DATA_W-1:0] pat;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   idx;
  logic [WD_W-1:0]   wdog;
  logic              last_idx;

  sdram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pat (
    .mode  (mode_r),
    .seed  (seed_r),
    .index (idx),
    .addr  (addr_r),
    .data  (pat)
  );

  // addr_r tracks base+idx incrementally so the address needs no adder on the output
  assign mem_addr  = addr_r;
  assign mem_wdata = mem_write ? pat : '0;
  assign last_idx  = (idx == count_r - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      mode_r         <= PAT_CONST;
      seed_r         <= '0;
      base_r         <= '0;
      addr_r         <= '0;
      count_r        <= '0;
      idx            <= '0;
      wdog           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_act  <= '0;
      mem_enable     <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: if (start) begin
          mode_r         <= pat_mode_t'(mode);
          seed_r         <= seed;
          base_r         <= base_addr;
          addr_r         <= base_addr;
          count_r        <= count;
          idx            <= '0;
          wdog           <= '0;
          busy           <= 1'b1;
          pass           <= 1'b0;
          timeout        <= 1'b0;
          err_count      <= '0;
          first_err_addr <= '0;
          first_err_exp  <= '0;
          first_err_act  <= '0;
          if (count == '0) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            mem_enable <= 1'b1;
            mem_write  <= 1'b1;
            state      <= ST_WREQ;
          end
        end
        ST_WREQ, ST_RREQ: begin
          if (mem_ready) begin
            mem_enable <= 1'b0;
            if (state == ST_WREQ) begin
              state <= ST_WGAP;
            end else begin
              state <= ST_RGAP;
              if (mem_rdata != pat) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                  first_err_addr <= addr_r;
                  first_err_exp  <= pat;
                  first_err_act  <= mem_rdata;
                end
              end
            end
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            timeout    <= 1'b1;
            pass       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_FIN;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_WGAP: begin
          wdog       <= '0;
          mem_enable <= 1'b1;
          if (last_idx) begin
            idx       <= '0;
            addr_r    <= base_r;
            mem_write <= 1'b0;
            state     <= ST_RREQ;
          end else begin
            idx    <= idx + 1'b1;
            addr_r <= addr_r + 1'b1;
            state  <= ST_WREQ;
          end
        end
        ST_RGAP: begin
          wdog <= '0;
          if (last_idx) begin
            pass  <= (err_count == '0);
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            idx        <= idx + 1'b1;
            addr_r     <= addr_r + 1'b1;
            mem_enable <= 1'b1;
            state      <= ST_RREQ;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_tester.sv
// Bench: random-latency memory responder plus a transaction-level scoreboard of the tester.
module tb_sdram_tester;

  logic        clk, rst, start;
  logic [1:0]  mode;
  logic [23:0] base_addr;
  logic [24:0] count;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic [31:0] first_err_exp, first_err_act;
  logic        mem_enable, mem_write, mem_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  sdram_tester #(.DATA_W(32), .ADDR_W(24), .ERR_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    logic [31:0] data;
  } txn_t;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  txn_t exp_q[$];
  logic [23:0] obs_addr[$];
  logic [31:0] obs_wd[$];
  logic        obs_wr[$];
  logic [31:0] mem [logic [23:0]];

  // model state
  logic [15:0] m_err;
  logic [23:0] m_faddr;
  logic [31:0] m_fexp, m_fact;
  bit          exp_to, flip_en;
  logic [23:0] flip_addr;
  int          stall_n = 0, wr_num = 0, en_len = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] s, input int i,
                                      input logic [23:0] a);
    int r;
    r = i % 32;
    case (m)
      2'd0:    return s;
      2'd1:    return {8'h00, a};
      2'd2:    return s + 32'(i);
      default: return (r == 0) ? s : ((s << r) | (s >> (32 - r)));
    endcase
  endfunction

  // responder and checker share one process so mem_ready is decided before it is checked
  initial begin : mon
    bit in_req, stalled, hs, hs1, hs2, prev_en, prev_done;
    int lat, rise_cyc;
    logic [23:0] prev_addr;
    logic [31:0] prev_wd, rd;
    logic prev_wr;
    txn_t e;
    in_req = 0; stalled = 0; hs1 = 0; hs2 = 0; prev_en = 0; prev_done = 0; lat = 0; rise_cyc = 0;
    prev_addr = '0; prev_wd = '0; prev_wr = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst) begin
        in_req = 0; hs1 = 0; hs2 = 0; prev_en = 0; prev_done = 0;
      end else begin
        if (!mem_enable) in_req = 0;
        else begin
          if (!in_req) begin
            in_req = 1;
            lat = $urandom_range(0, 3);
            if (mem_write) wr_num++;
            stalled = mem_write && (wr_num == stall_n);
          end
          if (!stalled) begin
            if (lat == 0) begin
              if (mem_write) mem[mem_addr] = mem_wdata;
              else begin
                rd = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                if (flip_en && mem_addr == flip_addr) rd = rd ^ 32'h1;
                mem_rdata = rd;
              end
              mem_ready = 1'b1;
              in_req = 0;
            end else lat--;
          end
        end
        if (mem_enable && !prev_en) rise_cyc = cyc;
        if (!mem_enable && prev_en) en_len = cyc - rise_cyc;
        if (hs1) chk("gap_after_ready", 64'(mem_enable), 64'd0);
        if (hs2) begin
          if (exp_q.size() > 0) chk("next_request", 64'(mem_enable), 64'd1);
          else chk("done_after_last", 64'(done), 64'd1);
        end
        if (prev_en && !hs1 && mem_enable) begin
          chk("stable_addr", 64'(mem_addr), 64'(prev_addr));
          chk("stable_write", 64'(mem_write), 64'(prev_wr));
          chk("stable_wdata", 64'(mem_wdata), 64'(prev_wd));
        end
        hs = mem_enable && mem_ready;
        if (hs) begin
          chk("busy_in_txn", 64'(busy), 64'd1);
          obs_addr.push_back(mem_addr);
          obs_wd.push_back(mem_wdata);
          obs_wr.push_back(mem_write);
          if (exp_q.size() == 0) chk("unexpected_txn", 64'(mem_addr), 64'hDEAD);
          else begin
            e = exp_q.pop_front();
            chk("txn_addr", 64'(mem_addr), 64'(e.addr));
            chk("txn_write", 64'(mem_write), 64'(e.wr));
            chk("txn_wdata", 64'(mem_wdata), e.wr ? 64'(e.data) : 64'd0);
            if (!e.wr && mem_rdata != e.data) begin
              if (m_err == 0) begin
                m_faddr = e.addr; m_fexp = e.data; m_fact = mem_rdata;
              end
              if (m_err != 16'hFFFF) m_err++;
            end
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_one_cycle", 64'(prev_done), 64'd0);
          chk("err_count", 64'(err_count), 64'(m_err));
          chk("pass", 64'(pass), 64'(m_err == 0 && !exp_to));
          chk("timeout", 64'(timeout), 64'(exp_to));
          chk("first_err_addr", 64'(first_err_addr), 64'(m_faddr));
          chk("first_err_exp", 64'(first_err_exp), 64'(m_fexp));
          chk("first_err_act", 64'(first_err_act), 64'(m_fact));
          if (!exp_to) chk("all_txn_done", 64'(exp_q.size()), 64'd0);
        end
        if (prev_done) chk("idle_after_done", 64'(busy), 64'd0);
        hs2 = hs1; hs1 = hs; prev_en = mem_enable; prev_done = done;
        prev_addr = mem_addr; prev_wd = mem_wdata; prev_wr = mem_write;
      end
    end
  end

  task automatic arm(input logic [1:0] m, input logic [23:0] b, input logic [24:0] c,
                     input logic [31:0] s, input bit fl, input logic [23:0] fa, input int stl);
    exp_q.delete(); obs_addr.delete(); obs_wd.delete(); obs_wr.delete();
    m_err = 0; m_faddr = 0; m_fexp = 0; m_fact = 0;
    wr_num = 0; stall_n = stl; flip_en = fl; flip_addr = fa;
    exp_to = (stl > 0) && (stl <= int'(c));
    for (int i = 0; i < int'(c); i++) exp_q.push_back('{b + 24'(i), 1'b1, pat(m, s, i, b + 24'(i))});
    for (int i = 0; i < int'(c); i++) exp_q.push_back('{b + 24'(i), 1'b0, pat(m, s, i, b + 24'(i))});
    @(posedge clk); #2;
    start = 1'b1; mode = m; base_addr = b; count = c; seed = s;
    @(posedge clk); #2;
    start = 1'b0; mode = 2'($urandom); base_addr = 24'($urandom); count = 25'($urandom); seed = $urandom;
  endtask

  task automatic finish_test(input int d0, input int mid);
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      @(posedge clk); #2;
      start = (k == mid);
    end
    start = 1'b0;
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    repeat (3) @(negedge clk);
    chk("hold_pass", 64'(pass), 64'(m_err == 0 && !exp_to));
    chk("hold_err_count", 64'(err_count), 64'(m_err));
  endtask

  task automatic run_test(input logic [1:0] m, input logic [23:0] b, input logic [24:0] c,
                          input logic [31:0] s, input bit fl, input logic [23:0] fa,
                          input int stl, input int mid);
    int d0;
    d0 = done_cnt;
    arm(m, b, c, s, fl, fa, stl);
    finish_test(d0, mid);
  endtask

  initial begin : stim
    logic [23:0] ea[4];
    logic [23:0] b, fa;
    logic [24:0] c;
    int d0;
    rst = 1'b1; start = 1'b0; mode = '0; base_addr = '0; count = '0; seed = '0;
    m_err = 0; m_faddr = 0; m_fexp = 0; m_fact = 0; exp_to = 0; flip_en = 0; flip_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_enable", 64'(mem_enable), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_first_err", 64'({first_err_addr, first_err_exp}), 64'd0);
    chk("rst_first_act", 64'(first_err_act), 64'd0);
    @(posedge clk); #2 rst = 1'b0;

    // single word, constant pattern
    run_test(2'd0, 24'h0, 25'd1, 32'hFFFF_FFFF, 0, 24'h0, 0, -1);
    chk("s1_txns", 64'(obs_addr.size()), 64'd2);
    chk("s1_waddr", 64'(obs_addr[0]), 64'h0);
    chk("s1_wdata", 64'(obs_wd[0]), 64'hFFFF_FFFF);
    chk("s1_read", 64'({obs_wr[1], obs_addr[1]}), 64'h0);
    chk("s1_pass", 64'(pass), 64'd1);

    // incrementing pattern across the address wrap
    run_test(2'd2, 24'hFF_FFFE, 25'd4, 32'd10, 0, 24'h0, 0, -1);
    ea = '{24'hFF_FFFE, 24'hFF_FFFF, 24'h00_0000, 24'h00_0001};
    for (int i = 0; i < 4; i++) begin
      chk("s2_addr", 64'(obs_addr[i]), 64'(ea[i]));
      chk("s2_data", 64'(obs_wd[i]), 64'(10 + i));
    end
    chk("s2_pass", 64'(pass), 64'd1);

    // address pattern with one corrupted read
    run_test(2'd1, 24'h0, 25'd8, 32'h1234, 1, 24'd5, 0, -1);
    chk("s3_err_count", 64'(err_count), 64'd1);
    chk("s3_first_addr", 64'(first_err_addr), 64'd5);
    chk("s3_first_exp", 64'(first_err_exp), 64'd5);
    chk("s3_first_act", 64'(first_err_act), 64'd4);
    chk("s3_pass", 64'(pass), 64'd0);

    // third write never completes
    run_test(2'd0, 24'h100, 25'd8, 32'hA5A5_A5A5, 0, 24'h0, 3, -1);
    chk("s4_timeout", 64'(timeout), 64'd1);
    chk("s4_pass", 64'(pass), 64'd0);
    chk("s4_enable_len", 64'(en_len), 64'd16);
    chk("s4_txns", 64'(obs_addr.size()), 64'd2);

    // walking one past a full rotation, with a start pulse mid-test
    run_test(2'd3, 24'h40, 25'd34, 32'd1, 0, 24'h0, 0, 20);
    chk("s5_txns", 64'(obs_wd.size()), 64'd68);
    chk("s5_idx33", 64'({obs_wr[33], obs_wd[33]}), 64'h1_0000_0002);
    chk("s5_pass", 64'(pass), 64'd1);

    // reset during the read pass
    d0 = done_cnt;
    arm(2'd2, 24'h300, 25'd8, 32'h55, 0, 24'h0, 0);
    for (int k = 0; k < 500 && obs_addr.size() < 11; k++) @(posedge clk);
    chk("s6_in_read", 64'(obs_addr.size() >= 11), 64'd1);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("s6_enable", 64'(mem_enable), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_err_count", 64'(err_count), 64'd0);
    repeat (20) @(negedge clk);
    chk("s6_no_done", 64'(done_cnt), 64'(d0));
    run_test(2'd2, 24'h300, 25'd8, 32'h55, 0, 24'h0, 0, -1);

    for (int t = 0; t < 10; t++) begin
      b  = ($urandom_range(0, 1) == 1) ? 24'hFF_FFF8 + 24'($urandom_range(0, 7)) : 24'($urandom);
      c  = 25'($urandom_range(0, 10));
      fa = b + 24'($urandom_range(0, (c > 0) ? int'(c) - 1 : 0));
      run_test(2'($urandom), b, c, $urandom, bit'($urandom_range(0, 1)), fa, 0,
               ($urandom_range(0, 1) == 1) ? $urandom_range(3, 30) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : guard
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "bench time limit");
  end

endmodule
